// File: rtl/cpu_pkg.sv
// Shared CPU definitions: Wishbone widths, fetch-FSM encodings and the reset vector
// (the reset vector is also used by the CPU register file).
package cpu_pkg;

    localparam int WB_DW = 32;
    localparam int WB_AW = 32;

    localparam logic [WB_AW-1:0] CPU_RESET_PC = 32'hB000_0000;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_BUS   = 2'd1,
        IF_FAULT = 2'd2
    } if_state_t;

    function automatic logic [WB_AW-1:0] word_align(input logic [WB_AW-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head word; push/pop in the same cycle is legal even when
// full. Flush and reset empty it and zero the output.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_nxt;
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] head_nxt;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // The head after this edge is the pushed word only when nothing older remains.
    always_comb begin
        rd_ptr_nxt = rd_ptr + AW'(do_pop);
        count_nxt  = count_q + CW'(do_push) - CW'(do_pop);
        head_nxt   = mem[rd_ptr_nxt];
        if (do_push && (count_q == CW'(do_pop))) begin
            head_nxt = din;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr  <= rd_ptr_nxt;
            count_q <= count_nxt;
            dout_q  <= (count_nxt != '0) ? head_nxt : '0;
        end
    end

    assign dout  = dout_q;
    assign valid = ~empty;
    assign count = count_q;

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction prefetch: pipelined Wishbone reads at a sequential PC into a small FIFO for decode.
//   state    | meaning
//   IF_IDLE  | no credit left (FIFO full, nothing in flight); bus released
//   IF_BUS   | cycle open; strobing while credit remains, collecting acks
//   IF_FAULT | bus error taken; no issuing until a redirect
module ifetch_prefetch
    import cpu_pkg::*;
#(
    parameter int               DEPTH    = 4,
    parameter logic [WB_AW-1:0] RESET_PC = CPU_RESET_PC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_redirect,
    input  logic [WB_AW-1:0] i_redirect_pc,
    output logic             o_wb_cyc,
    output logic             o_wb_stb,
    output logic [WB_AW-1:0] o_wb_addr,
    input  logic             i_wb_stall,
    input  logic             i_wb_ack,
    input  logic             i_wb_err,
    input  logic [WB_DW-1:0] i_wb_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WB_DW-1:0] o_instr,
    output logic [WB_AW-1:0] o_pc,
    output logic             o_fault,
    output logic [WB_AW-1:0] o_fault_pc
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    if_state_t state;
    if_state_t state_nxt;

    logic [WB_AW-1:0]       req_pc;
    logic [WB_AW-1:0]       rsp_pc;
    logic [CW-1:0]          outstanding;
    logic [CW-1:0]          fifo_count;
    logic [CW-1:0]          credit;
    logic                   has_credit;
    logic                   in_bus;
    logic                   take_ack;
    logic                   take_err;
    logic                   accept;
    logic                   pop;
    logic                   fifo_valid;
    logic [WB_AW+WB_DW-1:0] fifo_dout;
    logic                   fault_q;
    logic [WB_AW-1:0]       fault_pc_q;

    // Entries buffered plus requests in flight never exceed DEPTH, so acks always find room.
    assign credit     = DEPTH_C - fifo_count - outstanding;
    assign has_credit = (credit != '0);
    assign in_bus     = (state == IF_BUS);

    assign take_err = in_bus & i_wb_err & ~i_redirect;
    assign take_ack = in_bus & i_wb_ack & ~i_wb_err & ~i_redirect & (outstanding != '0);

    assign o_wb_cyc  = in_bus & ~i_redirect;
    assign o_wb_stb  = o_wb_cyc & has_credit & ~i_wb_err;
    assign o_wb_addr = req_pc;
    assign accept    = o_wb_stb & ~i_wb_stall;

    assign pop = fifo_valid & i_ready & ~i_redirect;

    // A redirect always reopens the bus next cycle: after the flush credit is DEPTH,
    // so passing through IF_IDLE would only add a dead cycle.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IF_IDLE: begin
                if (has_credit) begin
                    state_nxt = IF_BUS;
                end
            end
            IF_BUS: begin
                if (take_err) begin
                    state_nxt = IF_FAULT;
                end else if (!has_credit && (outstanding == '0)) begin
                    state_nxt = IF_IDLE;
                end
            end
            IF_FAULT: begin
                state_nxt = IF_FAULT;
            end
            default: begin
                state_nxt = IF_IDLE;
            end
        endcase
        if (i_redirect) begin
            state_nxt = IF_BUS;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IF_IDLE;
            req_pc      <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            fault_q     <= 1'b0;
            fault_pc_q  <= '0;
        end else if (i_redirect) begin
            state       <= state_nxt;
            req_pc      <= word_align(i_redirect_pc);
            rsp_pc      <= word_align(i_redirect_pc);
            outstanding <= '0;
            fault_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                req_pc <= req_pc + 32'd4;
            end
            if (take_ack) begin
                rsp_pc <= rsp_pc + 32'd4;
            end
            if (take_err) begin
                outstanding <= '0;
                fault_q     <= 1'b1;
                fault_pc_q  <= rsp_pc;
            end else begin
                outstanding <= outstanding + CW'(accept) - CW'(take_ack);
            end
        end
    end

    sync_fifo #(
        .WIDTH(WB_AW + WB_DW),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (i_redirect),
        .push  (take_ack),
        .din   ({rsp_pc, i_wb_data}),
        .pop   (pop),
        .dout  (fifo_dout),
        .valid (fifo_valid),
        .count (fifo_count)
    );

    assign o_valid    = fifo_valid;
    assign o_pc       = fifo_dout[WB_AW+WB_DW-1:WB_DW];
    assign o_instr    = fifo_dout[WB_DW-1:0];
    assign o_fault    = fault_q;
    assign o_fault_pc = fault_pc_q;

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Bench for ifetch_prefetch: a randomized Wishbone slave plus a queue-based model of requests,
// buffered words and fault state, with directed scenarios followed by random traffic.
module tb_ifetch_prefetch;
    import cpu_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'hB000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic [31:0] o_wb_addr;
    logic        i_wb_stall;
    logic        i_wb_ack;
    logic        i_wb_err;
    logic [31:0] i_wb_data;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        o_fault;
    logic [31:0] o_fault_pc;

    always #5 clk = ~clk;

    ifetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_addr(o_wb_addr),
        .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_data(i_wb_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_instr(o_instr), .o_pc(o_pc),
        .o_fault(o_fault), .o_fault_pc(o_fault_pc)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: addresses the slave has accepted but not answered, and words decode
    // has yet to receive, in program order.
    logic [31:0] pend[$];
    logic [31:0] exp_fifo[$];
    logic [31:0] exp_req_pc;
    logic        fault_m;
    logic [31:0] fault_pc_m;
    logic [31:0] key;
    logic        err_armed;
    logic [31:0] err_addr;
    int          stall_pct, ack_pct, ready_pct;
    logic        force_stall;
    int          n_accept, n_pop;
    logic [31:0] last_acc, last_pop_pc, seen_addr;
    logic        seen_stb;

    task automatic chk1(input string tag, input logic obs, input logic want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, want);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic clear_model(input logic [31:0] pc);
        pend.delete();
        exp_fifo.delete();
        exp_req_pc = pc;
        fault_m    = 1'b0;
        err_armed  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; i_redirect = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0;
        i_wb_stall = 1'b0; i_ready = 1'b0;
        @(posedge clk); #1;
        chk1("rst_cyc", o_wb_cyc, 1'b0);
        chk1("rst_stb", o_wb_stb, 1'b0);
        chk1("rst_valid", o_valid, 1'b0);
        chk1("rst_fault", o_fault, 1'b0);
        chk32("rst_fault_pc", o_fault_pc, 32'h0);
        chk32("rst_instr", o_instr, 32'h0);
        chk32("rst_pc", o_pc, 32'h0);
        chk32("rst_addr", o_wb_addr, RPC);
        @(posedge clk); #1;
        reset = 1'b0;
        clear_model(RPC);
        n_accept = 0; n_pop = 0; last_acc = '0; last_pop_pc = '0;
    endtask

    task automatic cycle();
        logic ack_now, err_now, stall_now, rdy_now, acc;
        logic [31:0] head;
        int infl;
        stall_now = force_stall || (int'($urandom_range(99)) < stall_pct);
        rdy_now   = (int'($urandom_range(99)) < ready_pct);
        ack_now = 1'b0; err_now = 1'b0; head = '0;
        if (pend.size() > 0 && int'($urandom_range(99)) < ack_pct) begin
            head = pend[0];
            if (err_armed && head == err_addr) err_now = 1'b1;
            else ack_now = 1'b1;
        end
        i_redirect = 1'b0; i_wb_stall = stall_now; i_ready = rdy_now;
        i_wb_ack = ack_now; i_wb_err = err_now;
        i_wb_data = ack_now ? (head ^ key) : $urandom();
        #1;
        seen_stb  = o_wb_stb;
        seen_addr = o_wb_addr;
        infl = pend.size() + exp_fifo.size();
        chk1("valid", o_valid, exp_fifo.size() > 0);
        chk1("fault", o_fault, fault_m);
        if (fault_m) begin
            chk32("fault_pc_hold", o_fault_pc, fault_pc_m);
            chk1("no_stb_after_err", o_wb_stb, 1'b0);
        end
        if (rdy_now && exp_fifo.size() > 0) begin
            chk32("pop_pc", o_pc, exp_fifo[0]);
            chk32("pop_instr", o_instr, exp_fifo[0] ^ key);
            last_pop_pc = exp_fifo.pop_front();
            n_pop++;
        end
        if (ack_now) exp_fifo.push_back(pend.pop_front());
        if (err_now) begin
            fault_m = 1'b1; fault_pc_m = head; pend.delete(); err_armed = 1'b0;
        end
        acc = o_wb_stb && !stall_now && !err_now;
        if (acc) begin
            chk32("req_addr", o_wb_addr, exp_req_pc);
            chk1("credit", infl < DEPTH, 1'b1);
            chk1("stb_has_cyc", o_wb_cyc, 1'b1);
            last_acc = o_wb_addr;
            pend.push_back(exp_req_pc);
            exp_req_pc += 32'd4;
            n_accept++;
        end
        @(posedge clk); #1;
    endtask

    task automatic redirect(input logic [31:0] tgt);
        i_redirect = 1'b1; i_redirect_pc = tgt; i_wb_ack = 1'b1; i_wb_err = 1'b0;
        i_wb_stall = 1'b0; i_ready = 1'b1; i_wb_data = $urandom();
        #1;
        chk1("redir_cyc_low", o_wb_cyc, 1'b0);
        chk1("redir_stb_low", o_wb_stb, 1'b0);
        @(posedge clk); #1;
        i_redirect = 1'b0; i_wb_ack = 1'b0; i_ready = 1'b0;
        clear_model(tgt & ~32'd3);
        #1;
        chk1("redir_fault_clr", o_fault, 1'b0);
        chk1("redir_flushed", o_valid, 1'b0);
        chk1("restart_cyc", o_wb_cyc, 1'b1);
        chk32("restart_addr", o_wb_addr, exp_req_pc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed still running, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        i_redirect_pc = '0; i_wb_data = '0; key = '0; force_stall = 1'b0;
        fault_pc_m = '0; err_addr = '0; seen_stb = 1'b0; seen_addr = '0;

        // Zero-wait slave, data = address, decode always ready.
        stall_pct = 0; ack_pct = 100; ready_pct = 100;
        do_reset();
        cycle(); chk1("release_no_stb", seen_stb, 1'b0);
        cycle(); chk1("first_stb", seen_stb, 1'b1); chk32("first_addr", last_acc, RPC);
        repeat (20) cycle();
        chk1("stream_progress", n_pop >= 10, 1'b1);

        // Decode stalled: credit caps the burst at DEPTH.
        do_reset(); ready_pct = 0;
        repeat (12) cycle();
        chk32("hold_accepts", 32'(n_accept), 32'd4);
        chk1("hold_stb_low", seen_stb, 1'b0);
        chk32("hold_head_pc", o_pc, RPC);
        ready_pct = 100;
        for (int i = 0; i < 20 && n_accept < 5; i++) cycle();
        chk32("resume_addr", last_acc, RPC + 32'd16);

        // Slave stall on the second request.
        do_reset();
        cycle(); cycle();
        force_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk32("stall_addr", seen_addr, RPC + 32'd4);
            chk1("stall_stb", seen_stb, 1'b1);
        end
        force_stall = 1'b0;
        chk32("stall_accepts", 32'(n_accept), 32'd1);
        repeat (10) cycle();

        // Redirect with two requests outstanding.
        do_reset(); ack_pct = 0;
        for (int i = 0; i < 10 && pend.size() < 2; i++) cycle();
        chk32("two_outstanding", 32'(pend.size()), 32'd2);
        redirect(32'h0000_1237);
        ack_pct = 100; ready_pct = 100; n_pop = 0;
        for (int i = 0; i < 20 && n_pop < 1; i++) cycle();
        chk32("redir_first_pc", last_pop_pc, 32'h0000_1234);

        // Bus error on the third request.
        do_reset(); ready_pct = 0; err_addr = RPC + 32'd8; err_armed = 1'b1;
        for (int i = 0; i < 20 && !fault_m; i++) cycle();
        chk1("fault_set", o_fault, 1'b1);
        chk32("fault_pc", o_fault_pc, RPC + 32'd8);
        repeat (4) cycle();
        chk32("fault_head", o_pc, RPC);
        ready_pct = 100; n_pop = 0;
        repeat (6) cycle();
        chk32("drained", 32'(n_pop), 32'd2);
        chk32("drain_last", last_pop_pc, RPC + 32'd4);
        redirect(32'h0000_2000);

        // Address wrap, then reset in the middle of traffic.
        redirect(32'hFFFF_FFFC);
        n_accept = 0;
        for (int i = 0; i < 10 && n_accept < 2; i++) cycle();
        chk32("wrap_addr", last_acc, 32'h0000_0000);
        stall_pct = 30; ack_pct = 70;
        repeat (5) cycle();
        do_reset();

        // Random traffic with occasional redirects and bus errors.
        key = $urandom(); stall_pct = 30; ack_pct = 60; ready_pct = 70;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) == 0) begin
                redirect($urandom());
            end else begin
                if (!err_armed && !fault_m && $urandom_range(199) == 0) begin
                    err_armed = 1'b1;
                    err_addr  = exp_req_pc;
                end
                cycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
